// File: rtl/spi_slave_regs.sv
`timescale 1ns/1ps
// spi_slave_regs: SPI mode-0 slave exposing a bank of 2**ADDR_W 8-bit registers.
//
// Transaction: cs low, command byte (bit7 = write, low ADDR_W bits = address)
// while the slave shifts out status 8'h5A, then one data byte (read data out on
// MISO, or write data in on MOSI). All SPI inputs are resynchronised into clk_i;
// sclk must be at most clk_i/8.
//
// Optional feature: define SPI_REGS_AUTOINC_EN to let further bytes in the same
// cs-low window continue at address+1 (wrapping). Without it, those bytes are
// ignored and MISO stays 0.
//
// Ports:
//   clk_i        system clock (rising edge)
//   rst_i        asynchronous active-low reset
//   spi_sclk_i   SPI clock from the master (asynchronous)
//   spi_cs_i     chip select, active-low
//   spi_mosi_i   master-out data
//   spi_miso_o   slave-out data (0 when idle)
//   host_addr_i  host-side read address
//   host_data_bo registered host-side read data
//   wr_strobe_o  one-cycle pulse per SPI register write
//   wr_addr_bo   address of the last SPI write
//   wr_data_bo   data of the last SPI write
//   busy_o       high while synchronised cs is low
module spi_slave_regs #(
    parameter int unsigned ADDR_W  = 4,
    parameter logic [7:0]  REG_RST = 8'h00
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    input  logic [ADDR_W-1:0] host_addr_i,
    output logic [7:0]        host_data_bo,
    output logic              wr_strobe_o,
    output logic [ADDR_W-1:0] wr_addr_bo,
    output logic [7:0]        wr_data_bo,
    output logic              busy_o
);

    localparam int unsigned       NumRegs = 1 << ADDR_W;
    localparam logic [7:0]        Status  = 8'h5A;
    localparam logic [ADDR_W-1:0] AddrOne = 1;

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_t;

    // Synchronisers and edge detection
    logic sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic cs_meta_q, cs_sync_q, cs_prev_q;
    logic mosi_meta_q, mosi_sync_q;
    logic [1:0] flush_q;
    logic armed_q;

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_prev_q   <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            flush_q     <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sclk_meta_q <= spi_sclk_i;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= spi_cs_i;
            cs_sync_q   <= cs_meta_q;
            cs_prev_q   <= cs_sync_q;
            mosi_meta_q <= spi_mosi_i;
            mosi_sync_q <= mosi_meta_q;
            flush_q     <= {flush_q[0], 1'b1};
            // Only accept a cs fall once a genuine high has been seen after reset;
            // otherwise a cs held low across reset would look like a new start.
            armed_q     <= armed_q | (flush_q[1] & cs_sync_q);
        end
    end

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_fall   = armed_q & cs_prev_q & ~cs_sync_q;
    assign cs_rise   = cs_sync_q & ~cs_prev_q;

    // Transaction FSM, register bank and write reporting
    state_t            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        rx_q;
    logic [7:0]        tx_q;
    logic              miso_q;
    logic              is_wr_q;
    logic              done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        regs_q [NumRegs];
    logic [1:0]        wr_pend_q;
    logic [ADDR_W-1:0] pend_addr_q;
    logic [7:0]        pend_data_q;
    logic              wr_strobe_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_nxt;

    assign rx_byte  = {rx_q[6:0], mosi_sync_q};
    assign addr_nxt = addr_q + AddrOne;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 8'h00;
            tx_q        <= 8'h00;
            miso_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            done_q      <= 1'b0;
            addr_q      <= '0;
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= REG_RST;
            end
            wr_pend_q   <= 2'b00;
            pend_addr_q <= '0;
            pend_data_q <= 8'h00;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= 8'h00;
        end else begin
            // Strobe trails the register write by two cycles
            wr_pend_q   <= {wr_pend_q[0], 1'b0};
            wr_strobe_q <= wr_pend_q[1];
            if (wr_pend_q[1]) begin
                wr_addr_q <= pend_addr_q;
                wr_data_q <= pend_data_q;
            end

            if (cs_rise) begin
                // Any partial byte is dropped here without touching the bank
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
                miso_q    <= 1'b0;
                done_q    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (cs_fall) begin
                            state_q   <= StCmd;
                            bit_cnt_q <= 3'd0;
                            done_q    <= 1'b0;
                            miso_q    <= Status[7];
                            tx_q      <= {Status[6:0], 1'b0};
                        end
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                state_q <= StData;
                                is_wr_q <= rx_byte[7];
                                addr_q  <= rx_byte[ADDR_W-1:0];
                                tx_q    <= rx_byte[7] ? 8'h00 : regs_q[rx_byte[ADDR_W-1:0]];
                            end
                        end else if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                    StData: begin
                        if (sclk_rise) begin
                            rx_q      <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7 && !done_q) begin
                                if (is_wr_q) begin
                                    regs_q[addr_q] <= rx_byte;
                                    wr_pend_q[0]   <= 1'b1;
                                    pend_addr_q    <= addr_q;
                                    pend_data_q    <= rx_byte;
                                end
`ifdef SPI_REGS_AUTOINC_EN
                                addr_q <= addr_nxt;
                                tx_q   <= is_wr_q ? 8'h00 : regs_q[addr_nxt];
`else
                                done_q <= 1'b1;
                                tx_q   <= 8'h00;
`endif
                            end
                        end else if (sclk_fall) begin
                            miso_q <= tx_q[7];
                            tx_q   <= {tx_q[6:0], 1'b0};
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Host read port
    logic [7:0] host_data_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            host_data_q <= 8'h00;
        end else begin
            host_data_q <= regs_q[host_addr_i];
        end
    end

    assign spi_miso_o   = miso_q;
    assign host_data_bo = host_data_q;
    assign wr_strobe_o  = wr_strobe_q;
    assign wr_addr_bo   = wr_addr_q;
    assign wr_data_bo   = wr_data_q;
    assign busy_o       = ~cs_sync_q;

endmodule

// File: tb/tb_spi_slave_regs.sv
`timescale 1ns/1ps
// Self-checking bench for spi_slave_regs: transaction-level register model,
// per-cycle compare process, directed SPI transfers with literal expectations.
module tb_spi_slave_regs;

`ifdef SPI_REGS_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic       clk;
    logic       rst_i;
    logic       sclk;
    logic       cs;
    logic       mosi;
    logic       spi_miso_o;
    logic [3:0] host_addr;
    logic [7:0] host_data_bo;
    logic       wr_strobe_o;
    logic [3:0] wr_addr_bo;
    logic [7:0] wr_data_bo;
    logic       busy_o;

    spi_slave_regs dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .spi_sclk_i   (sclk),
        .spi_cs_i     (cs),
        .spi_mosi_i   (mosi),
        .spi_miso_o   (spi_miso_o),
        .host_addr_i  (host_addr),
        .host_data_bo (host_data_bo),
        .wr_strobe_o  (wr_strobe_o),
        .wr_addr_bo   (wr_addr_bo),
        .wr_data_bo   (wr_data_bo),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [7:0]  mem [16];
    logic [11:0] exp_q [$];
    logic [3:0]  last_addr;
    logic [7:0]  last_data;
    logic        prev_strobe;
    logic        quiet;
    logic        h1, h2;
    logic [7:0]  rxb [3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model
    always begin
        logic       r;
        logic       q;
        logic [7:0] eh;
        logic       eb;
        logic       zero;
        logic [11:0] e;
        @(posedge clk);
        r = rst_i;
        if (!r) begin
            h1 = 1'b1;
            h2 = 1'b1;
        end else begin
            h2 = h1;
            h1 = cs;
        end
        eh   = r ? mem[host_addr] : 8'h00;
        eb   = r ? ~h2 : 1'b0;
        q    = quiet;
        zero = 1'b0;
        #2;
        check("busy", busy_o, eb);
        if (q) begin
            check("host_data", host_data_bo, eh);
            check("miso_idle", spi_miso_o, zero);
        end
        if (!r) begin
            last_addr   = 4'h0;
            last_data   = 8'h00;
            prev_strobe = 1'b0;
        end
        if (wr_strobe_o) begin
            check("strobe_width", prev_strobe, zero);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_unexpected: strobe with addr %0h data %0h, none expected at %0t",
                         wr_addr_bo, wr_data_bo, $time);
            end else begin
                e = exp_q.pop_front();
                check("strobe_addr", wr_addr_bo, e[11:8]);
                check("strobe_data", wr_data_bo, e[7:0]);
                last_addr = e[11:8];
                last_data = e[7:0];
            end
        end
        check("wr_addr_hold", wr_addr_bo, last_addr);
        check("wr_data_hold", wr_data_bo, last_data);
        prev_strobe = wr_strobe_o;
    end

    // One SPI bit: sclk low for 4 clk, sample MISO, sclk high for 4 clk
    task automatic spi_bit(input logic b, output logic m);
        @(negedge clk);
        mosi = b;
        repeat (3) @(negedge clk);
        m    = spi_miso_o;
        sclk = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, input int nb, output logic [7:0] m);
        logic bit_m;
        m = 8'h00;
        for (int i = 0; i < nb; i++) begin
            spi_bit(b[7-i], bit_m);
            m = {m[6:0], bit_m};
        end
    endtask

    // Full transfer of nbits bits from {b0,b1,b2}; the model predicts MISO
    // bytes and writes from the command before the transfer starts.
    task automatic spi_xfer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int nbits);
        logic [7:0] tx [3];
        logic [7:0] exp_m [3];
        logic       chk_m [3];
        logic [3:0] wa [3];
        logic [7:0] wd [3];
        logic       we [3];
        logic [7:0] got;
        int         nfull;
        int         nb;
        tx[0] = b0;
        tx[1] = b1;
        tx[2] = b2;
        nfull = nbits / 8;
        for (int k = 0; k < 3; k++) begin
            chk_m[k] = 1'b0;
            we[k]    = 1'b0;
            exp_m[k] = 8'h00;
            wa[k]    = 4'h0;
            wd[k]    = 8'h00;
            rxb[k]   = 8'h00;
        end
        if (nfull >= 1) begin
            exp_m[0] = 8'h5A;
            chk_m[0] = 1'b1;
        end
        for (int k = 1; k < 3; k++) begin
            if (k < nfull) begin
                if (k == 1 || AUTOINC) begin
                    wa[k] = b0[3:0] + 4'(k - 1);
                    if (b0[7]) begin
                        we[k] = 1'b1;
                        wd[k] = tx[k];
                        exp_q.push_back({wa[k], tx[k]});
                    end else begin
                        exp_m[k] = mem[wa[k]];
                        chk_m[k] = 1'b1;
                    end
                end else begin
                    exp_m[k] = 8'h00;
                    chk_m[k] = 1'b1;
                end
            end
        end

        quiet = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (k * 8 < nbits) begin
                nb = (nbits - k * 8 >= 8) ? 8 : nbits - k * 8;
                spi_byte(tx[k], nb, got);
                rxb[k] = got;
            end
        end
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            if (chk_m[k]) check($sformatf("miso_byte%0d", k), rxb[k], exp_m[k]);
        end
        check("strobe_pending", exp_q.size(), 0);
        for (int k = 0; k < 3; k++) begin
            if (we[k]) mem[wa[k]] = wd[k];
        end
        quiet = 1'b1;
    endtask

    task automatic host_sweep();
        for (int a = 0; a < 16; a++) begin
            @(negedge clk);
            host_addr = 4'(a);
            @(negedge clk);
        end
    endtask

    task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string name);
        @(negedge clk);
        host_addr = a;
        @(negedge clk);
        check(name, host_data_bo, exp);
    endtask

    initial begin
        logic [7:0] got;
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        last_addr   = 4'h0;
        last_data   = 8'h00;
        prev_strobe = 1'b0;
        quiet       = 1'b1;
        rst_i       = 1'b0;
        sclk        = 1'b0;
        cs          = 1'b1;
        mosi        = 1'b0;
        host_addr   = 4'h0;
        repeat (5) @(negedge clk);
        check("rst_miso", spi_miso_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        rst_i = 1'b1;
        repeat (5) @(negedge clk);

        // Reset values over the whole bank
        host_sweep();
        host_read(4'd9, 8'h00, "host_rst_reg9");

        // Write 0xAC to reg 3
        spi_xfer(8'h83, 8'hAC, 8'h00, 16);
        check("wr_status_lit", rxb[0], 8'h5A);
        check("wr_addr_lit", wr_addr_bo, 4'd3);
        check("wr_data_lit", wr_data_bo, 8'hAC);
        host_read(4'd3, 8'hAC, "host_reg3_lit");

        // Read back reg 3
        spi_xfer(8'h03, 8'h00, 8'h00, 16);
        check("rd_data_lit", rxb[1], 8'hAC);

        // Aborted write to reg 5 after 4 data bits, then a normal one
        spi_xfer(8'h85, 8'hA5, 8'h00, 12);
        host_read(4'd5, 8'h00, "host_reg5_abort_lit");
        spi_xfer(8'h85, 8'h3C, 8'h00, 16);
        host_read(4'd5, 8'h3C, "host_reg5_lit");

        // Multi-byte write from reg 15 (wraps to reg 0 with auto-increment)
        spi_xfer(8'h8F, 8'h11, 8'h22, 24);
        host_read(4'd15, 8'h11, "host_reg15_lit");
`ifdef SPI_REGS_AUTOINC_EN
        host_read(4'd0, 8'h22, "host_reg0_lit");
`else
        host_read(4'd0, 8'h00, "host_reg0_lit");
`endif
        spi_xfer(8'h0F, 8'h00, 8'h00, 24);
        host_sweep();

        // Reset in the middle of a write data byte, cs held low across it
        quiet = 1'b0;
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        spi_byte(8'h84, 8, got);
        spi_byte(8'hF0, 4, got);
        @(negedge clk);
        rst_i = 1'b0;
        repeat (3) @(negedge clk);
        for (int a = 0; a < 16; a++) mem[a] = 8'h00;
        rst_i = 1'b1;
        spi_byte(8'h0F, 4, got);
        spi_byte(8'hFF, 8, got);
        check("miso_after_rst", got, 8'h00);
        repeat (4) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
        check("strobe_pending_rst", exp_q.size(), 0);
        quiet = 1'b1;
        host_read(4'd3, 8'h00, "host_reg3_after_rst_lit");
        host_read(4'd4, 8'h00, "host_reg4_after_rst_lit");
        host_sweep();

        // Normal operation resumes
        spi_xfer(8'h81, 8'h5C, 8'h00, 16);
        spi_xfer(8'h01, 8'h00, 8'h00, 16);
        check("rd_after_rst_lit", rxb[1], 8'h5C);
        host_sweep();

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_regs.md
SPI_SLAVE_REGS -- requirements
Module: spi_slave_regs

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning the register address width (2**ADDR_W 8-bit registers).
REQ-002 The block SHALL have parameter REG_RST, default 8'h00, meaning the reset value of every register.
REQ-003 The block SHALL have port clk_i  input  1  system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port spi_sclk_i  input  1  SPI clock from the master, asynchronous to clk_i.
REQ-006 The block SHALL have port spi_cs_i  input  1  chip select from the master, active-low.
REQ-007 The block SHALL have port spi_mosi_i  input  1  master-out data.
REQ-008 The block SHALL have port spi_miso_o  output  1  slave-out data.
REQ-009 The block SHALL have port host_addr_i  input  ADDR_W  host-side read address.
REQ-010 The block SHALL have port host_data_bo  output  8  host-side read data, registered.
REQ-011 The block SHALL have port wr_strobe_o  output  1  one-cycle pulse on each SPI register write.
REQ-012 The block SHALL have port wr_addr_bo  output  ADDR_W  address of the last SPI write.
REQ-013 The block SHALL have port wr_data_bo  output  8  data of the last SPI write.
REQ-014 The block SHALL have port busy_o  output  1  high while a transaction is in progress (cs low).

Function
REQ-015 The block SHALL synchronise spi_sclk_i, spi_cs_i and spi_mosi_i through 2-flop synchronisers and detect sclk edges from the synchronised signal; spi_sclk_i SHALL be supported up to clk_i/8.
REQ-016 The block SHALL implement SPI mode 0, MSB first, 8-bit bytes: sample MOSI on sclk rising, update MISO on sclk falling; the first MISO bit SHALL be driven on cs falling.
REQ-017 The FSM SHALL have states IDLE, CMD, DATA; IDLE->CMD on synchronised cs fall; CMD->DATA after 8 sclk rising edges; any state->IDLE on synchronised cs rise.
REQ-018 The command byte SHALL be bit7 = W (1 write, 0 read), bits6:ADDR_W unused, bits ADDR_W-1:0 = address.
REQ-019 During CMD, MISO SHALL shift out the status byte 8'h5A.
REQ-020 For a read, the register at the address SHALL be loaded into the shift register at CMD->DATA and shifted out on MISO during the data byte.
REQ-021 For a write, the received data byte SHALL be written to the register on its 8th sclk rising edge, with wr_strobe_o high for exactly one clk_i cycle two cycles later and wr_addr_bo/wr_data_bo updated in the same cycle.
REQ-022 A cs rise mid-byte SHALL discard the partial byte: no register write, no strobe, return to IDLE.
REQ-023 MISO SHALL output 0 in IDLE.
REQ-024 host_data_bo SHALL equal the register at host_addr_i one clk_i cycle after host_addr_i is applied; on a same-cycle SPI write to that address, the new value SHALL appear one cycle after the write.
REQ-025 busy_o SHALL follow synchronised cs inverted (2-cycle latency).

Reset
REQ-026 While rst_i is low, all registers SHALL be REG_RST, the FSM SHALL be IDLE, and spi_miso_o, wr_strobe_o, busy_o, wr_addr_bo, wr_data_bo and host_data_bo SHALL be 0.
REQ-027 Reset asserted mid-transaction SHALL abort it; after release the block SHALL ignore bits until the next cs fall.

Configuration
REQ-028 With macro SPI_REGS_AUTOINC_EN defined, each further byte after the first data byte in the same cs-low window SHALL address (previous address + 1) mod 2**ADDR_W, reading or writing as the command specifies.
REQ-029 Without SPI_REGS_AUTOINC_EN, bytes after the first data byte SHALL be ignored (no writes, MISO 0).

Verification
REQ-030 Reset, then host read of all addresses -> host_data_bo = 8'h00 for each.
REQ-031 SPI write cmd 8'h83, data 8'hAC -> MISO byte0 = 8'h5A; one wr_strobe_o pulse with wr_addr_bo = 3 and wr_data_bo = 8'hAC; host read addr 3 = 8'hAC.
REQ-032 After REQ-031, SPI read cmd 8'h03, dummy 8'h00 -> MISO byte1 = 8'hAC; no strobe.
REQ-033 Write cmd 8'h85, then cs raised after 4 data bits -> no strobe; reg 5 stays 8'h00; next transaction works normally.
REQ-034 With SPI_REGS_AUTOINC_EN, write cmd 8'h8F, then data 8'h11, 8'h22 -> reg 15 = 8'h11, reg 0 = 8'h22 (wrap); without the macro, reg 0 stays 8'h00.
REQ-035 rst_i pulsed low mid data byte of a write -> all registers 8'h00, no strobe, FSM IDLE.
